// File: rtl/fp_add_scheduler.sv
// Round-robin front end for the shared FP32 adder: grants one of two requesters,
// sequences the datapath (normal settle or bypass) and returns the captured sum.
module fp_add_scheduler #(
    parameter int ALU_CYCLES = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic [31:0]      dp_a,
    output logic [31:0]      dp_b,
    output logic             dp_start,
    input  logic             dp_bypass,
    input  logic [31:0]      dp_result,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp_result,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {IDLE, ALIGN, EXEC, RESP} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ALU_CYCLES - 1);

    state_t     state;
    logic       last;
    logic       owner;
    logic [3:0] cnt;
    logic       grant0;
    logic       grant1;
    logic       rsp_hs;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant0 = req0_valid && (!req1_valid || last);
        grant1 = req1_valid && (!req0_valid || !last);
        rsp_hs = owner ? (rsp1_valid && rsp1_ready) : (rsp0_valid && rsp0_ready);
    end

    assign req0_ready = (state == IDLE) && grant0;
    assign req1_ready = (state == IDLE) && grant1;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            last       <= 1'b1;
            owner      <= 1'b0;
            cnt        <= 4'd0;
            dp_a       <= 32'd0;
            dp_b       <= 32'd0;
            dp_start   <= 1'b0;
            rsp_result <= 32'd0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            ops_done   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        dp_a     <= grant1 ? req1_a : req0_a;
                        dp_b     <= grant1 ? req1_b : req0_b;
                        owner    <= grant1;
                        dp_start <= 1'b1;
                        state    <= ALIGN;
                    end
                end
                ALIGN: begin
                    dp_start <= 1'b0;
                    if (dp_bypass) begin
                        rsp_result <= dp_result;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end else begin
                        cnt   <= CNT_INIT;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_result <= dp_result;
                        rsp0_valid <= !owner;
                        rsp1_valid <= owner;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    // Returning to IDLE first keeps the handshake cycle free of a new grant.
                    if (rsp_hs) begin
                        last       <= owner;
                        ops_done   <= ops_done + 1'b1;
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
